bram_scan_ctrl: RTL and testbench

- Initiator-side controller for the 16x8 single-port block RAM.
- Drives the RAM's write-enable, address and write-data pins, and samples its read-data output.
- Fills the RAM with a seeded arithmetic pattern, reads it back, or does both in sequence.
- Reports pass/fail, mismatch count and the first failing address. Used for power-up self-test and for preloading lookup content.

---
 rtl/bram_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_bram_scan_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_scan_ctrl.sv
// Fill / verify controller for a single-port block RAM: writes the pattern seed+addr,
// reads it back through a RD_LAT-deep address pipeline and reports mismatch statistics.
module bram_scan_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FILL     = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [1:0]        OP_FILL   = 2'b00;
    localparam logic [1:0]        OP_VERIFY = 2'b01;
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] first_err_q, first_err_d;
    logic              pass_q, pass_d;

    // Read-side pipeline: stage RD_LAT-1 lines up with bram_dout.
    logic              pipe_v_q [RD_LAT];
    logic [ADDR_W-1:0] pipe_a_q [RD_LAT];

    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic              mismatch;

    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                  input logic [ADDR_W-1:0] a);
        return s + DATA_W'(a);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v_q[0] <= 1'b0;
            pipe_a_q[0] <= '0;
        end else begin
            pipe_v_q[0] <= (state_q == S_RD_ISSUE);
            pipe_a_q[0] <= addr_q;
        end
    end

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_v_q[gi] <= 1'b0;
                    pipe_a_q[gi] <= '0;
                end else begin
                    pipe_v_q[gi] <= pipe_v_q[gi-1];
                    pipe_a_q[gi] <= pipe_a_q[gi-1];
                end
            end
        end
    endgenerate

    assign cmp_valid = pipe_v_q[RD_LAT-1];
    assign cmp_addr  = pipe_a_q[RD_LAT-1];
    assign mismatch  = cmp_valid && (bram_dout != pattern(seed_q, cmp_addr));

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        op_d        = op_q;
        addr_d      = addr_q;
        lat_cnt_d   = lat_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;

        if (mismatch) begin
            err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
            if (err_cnt_q == '0) begin
                first_err_d = cmp_addr;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    seed_d      = seed;
                    op_d        = op;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                    addr_d      = '0;
                    state_d     = (op == OP_VERIFY) ? S_RD_ISSUE : S_FILL;
                end
            end
            S_FILL: begin
                if (addr_q == ADDR_MAX) begin
                    addr_d  = '0;
                    state_d = (op_q == OP_FILL) ? S_DONE : S_RD_ISSUE;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_RD_ISSUE: begin
                if (addr_q == ADDR_MAX) begin
                    lat_cnt_d = '0;
                    state_d   = S_RD_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_RD_DRAIN: begin
                // The final compare lands on this same edge, so judge on the next count.
                if (lat_cnt_q == LAT_LAST) begin
                    pass_d  = (err_cnt_d == '0);
                    state_d = S_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            seed_q      <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            lat_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            lat_cnt_q   <= lat_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
        end
    end

    // Write strobe decodes straight from state so it falls the instant reset asserts.
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;
    assign bram_we        = (state_q == S_FILL);
    assign bram_addr      = addr_q;
    assign bram_din       = (state_q == S_FILL) ? pattern(seed_q, addr_q) : '0;

endmodule

// File: tb/tb_bram_scan_ctrl.sv
// Scoreboard bench: two controllers (RD_LAT 1 and 3) each driving a behavioural RAM;
// expected writes and results are queued by the stimulus and popped by per-DUT monitors.
module tb_bram_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start_s [2];
    logic [1:0] op_s    [2];
    logic [7:0] seed_s  [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic       pass_w  [2];
    logic       we_w    [2];
    logic [4:0] errc_w  [2];
    logic [3:0] fe_w    [2];
    logic [3:0] addr_w  [2];
    logic [7:0] din_w   [2];
    logic [7:0] dout_w  [2];
    logic [7:0] mask    [2][16];

    typedef struct {int d; int a; int data; int lat;} wr_t;
    typedef struct {int d; int p; int e; int fe; int lat;} res_t;
    wr_t  wq[$];
    res_t rq[$];

    int n_vec = 0;
    int n_fail = 0;
    int ec = 0;
    int start_ec = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ec <= ec + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 1 : 3;
            logic [7:0] mem  [16];
            logic [7:0] pipe [3];

            bram_scan_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(LAT)) u_dut (
                .clk            (clk),
                .rst_n          (rst_n),
                .start          (start_s[gi]),
                .op             (op_s[gi]),
                .seed           (seed_s[gi]),
                .busy           (busy_w[gi]),
                .done           (done_w[gi]),
                .pass           (pass_w[gi]),
                .err_cnt        (errc_w[gi]),
                .first_err_addr (fe_w[gi]),
                .bram_we        (we_w[gi]),
                .bram_addr      (addr_w[gi]),
                .bram_din       (din_w[gi]),
                .bram_dout      (dout_w[gi])
            );

            always @(posedge clk) begin
                if (we_w[gi]) mem[addr_w[gi]] <= din_w[gi];
                pipe[0] <= mem[addr_w[gi]] ^ mask[gi][addr_w[gi]];
                pipe[1] <= pipe[0];
                pipe[2] <= pipe[1];
            end
            assign dout_w[gi] = pipe[LAT-1];

            always @(negedge clk) begin
                wr_t  w;
                res_t r;
                if (rst_n && we_w[gi]) begin
                    chk("write_expected", int'(wq.size() != 0), 1);
                    if (wq.size() != 0) begin
                        w = wq.pop_front();
                        chk("write_dut", gi, w.d);
                        chk("write_addr", int'(addr_w[gi]), w.a);
                        chk("write_data", int'(din_w[gi]), w.data);
                        chk("write_cycle", ec - start_ec, w.lat);
                        $display("write dut%0d addr=%0d data=0x%02h cycle=%0d",
                                 gi, addr_w[gi], din_w[gi], ec - start_ec);
                    end
                end
                if (rst_n && done_w[gi]) begin
                    chk("done_expected", int'(rq.size() != 0), 1);
                    if (rq.size() != 0) begin
                        r = rq.pop_front();
                        chk("done_dut", gi, r.d);
                        chk("pass", int'(pass_w[gi]), r.p);
                        chk("err_cnt", int'(errc_w[gi]), r.e);
                        chk("first_err_addr", int'(fe_w[gi]), r.fe);
                        chk("done_cycle", ec - start_ec, r.lat);
                        $display("done dut%0d pass=%0d err_cnt=%0d first_err=%0d cycle=%0d",
                                 gi, pass_w[gi], errc_w[gi], fe_w[gi], ec - start_ec);
                    end
                end
            end
        end
    endgenerate

    task automatic push_fill(input int d, input logic [7:0] seed, input int n);
        logic [7:0] v;
        for (int a = 0; a < n; a++) begin
            v = seed + 8'(a);
            wq.push_back('{d, a, int'(v), a + 1});
        end
    endtask

    task automatic launch(input int d, input logic [1:0] op, input logic [7:0] seed);
        @(negedge clk);
        op_s[d]   = op;
        seed_s[d] = seed;
        start_s[d] = 1'b1;
        start_ec  = ec;
        @(negedge clk);
        start_s[d] = 1'b0;
        op_s[d]   = ~op;
        seed_s[d] = ~seed;
    endtask

    task automatic wait_done(input int d);
        for (int i = 0; i < 200; i++) begin
            if (done_w[d]) break;
            @(negedge clk);
        end
        chk("done_seen", int'(done_w[d]), 1);
    endtask

    task automatic run(input int d, input logic [1:0] op, input logic [7:0] seed,
                       input bit fills, input int p, input int e, input int fe, input int lat);
        if (fills) push_fill(d, seed, 16);
        rq.push_back('{d, p, e, fe, lat});
        launch(d, op, seed);
        wait_done(d);
    endtask

    task automatic chk_idle_outputs(input int d, input string tag);
        chk({tag, "_busy"}, int'(busy_w[d]), 0);
        chk({tag, "_done"}, int'(done_w[d]), 0);
        chk({tag, "_pass"}, int'(pass_w[d]), 0);
        chk({tag, "_err_cnt"}, int'(errc_w[d]), 0);
        chk({tag, "_first_err"}, int'(fe_w[d]), 0);
        chk({tag, "_we"}, int'(we_w[d]), 0);
        chk({tag, "_addr"}, int'(addr_w[d]), 0);
        chk({tag, "_din"}, int'(din_w[d]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            op_s[d]    = 2'b00;
            seed_s[d]  = 8'h00;
            for (int a = 0; a < 16; a++) mask[d][a] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk_idle_outputs(0, "reset0");
        chk_idle_outputs(1, "reset1");
        rst_n = 1'b1;

        // Fill only, then fill-then-verify.
        run(0, 2'b00, 8'h30, 1'b1, 0, 0, 0, 17);
        run(0, 2'b10, 8'h30, 1'b1, 1, 0, 0, 34);

        // Verify against corrupted addresses 5 and 12.
        mask[0][5]  = 8'h04;
        mask[0][12] = 8'h80;
        run(0, 2'b01, 8'h30, 1'b0, 0, 2, 5, 18);
        repeat (3) @(negedge clk);
        chk("hold_err_cnt", int'(errc_w[0]), 2);
        chk("hold_first_err", int'(fe_w[0]), 5);
        mask[0][5]  = 8'h00;
        mask[0][12] = 8'h00;

        // Wrapping pattern, then op 11 behaving as fill-then-verify.
        run(0, 2'b10, 8'hF8, 1'b1, 1, 0, 0, 34);
        chk("wrap_mem7", int'(g_dut[0].mem[7]), 8'hFF);
        chk("wrap_mem8", int'(g_dut[0].mem[8]), 8'h00);
        chk("wrap_mem15", int'(g_dut[0].mem[15]), 8'h07);
        run(0, 2'b11, 8'hA0, 1'b1, 1, 0, 0, 34);

        // Ignored restart at addr 3, asynchronous abort at addr 7.
        push_fill(0, 8'h55, 8);
        launch(0, 2'b00, 8'h55);
        for (int i = 0; i < 40; i++) begin
            if (addr_w[0] == 4'd3) break;
            @(negedge clk);
        end
        chk("reach_addr3", int'(addr_w[0]), 3);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (addr_w[0] == 4'd7) break;
            @(negedge clk);
        end
        chk("reach_addr7", int'(addr_w[0]), 7);
        chk("we_before_abort", int'(we_w[0]), 1);
        #1 rst_n = 1'b0;
        #1 chk_idle_outputs(0, "abort");
        #1 rst_n = 1'b1;
        run(0, 2'b00, 8'h11, 1'b1, 0, 0, 0, 17);

        // RD_LAT = 3 instance.
        run(1, 2'b10, 8'h30, 1'b1, 1, 0, 0, 36);
        mask[1][15] = 8'h01;
        run(1, 2'b01, 8'h30, 1'b0, 0, 1, 15, 20);

        repeat (4) @(negedge clk);
        chk("writes_outstanding", int'(wq.size()), 0);
        chk("results_outstanding", int'(rq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
